stateful_processor_sequencer: RTL and testbench

Front-end controller for the replicated stateful processor (count-min / regex mains).
- Packs an upstream byte stream into REPLICATION_FACTOR-byte words.
- Issues one single-cycle enable per word with in_last tagging.
- Tracks in-flight results and buffers processor outputs in a credit-limited FIFO, so downstream backpressure (out_ready) is honoured even though the processor ignores it.

---
 rtl/stateful_processor_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_stateful_processor_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stateful_processor_sequencer.sv
// -----------------------------------------------------------------------------
// stateful_processor_sequencer
//
// Front-end controller for the replicated stateful processor. Packs an upstream
// byte stream into REPLICATION_FACTOR-byte words. Issues one single-cycle
// enable per word, tagged with the frame-closing flag. Buffers the processor's
// fixed-latency results in a credit-limited FIFO, so downstream backpressure is
// honoured even though the processor itself cannot stall.
//
// Optional feature macro: SEQ_FRAME_GAP_EN
//   When defined, the sequencer refuses new bytes after a frame-closing word
//   until every result of that frame has left the output FIFO.
//
// Ports:
//   clk_i, rst_ni              rising-edge clock, asynchronous active-low reset
//   s_data_i/s_valid_i/s_last_i/s_ready_o   upstream byte stream
//   p_enable_o, p_in_data_o, p_in_last_o     issue strobe and packed word
//   p_out_data_i, p_out_valid_i              processor result
//   m_data_o/m_valid_o/m_last_o/m_ready_i    downstream result stream
//   err_sync_o                 sticky: processor valid disagreed with tag pipe
//   busy_o                     partial word, in-flight issue or FIFO entry
// -----------------------------------------------------------------------------
module stateful_processor_sequencer #(
    parameter int unsigned REPLICATION_FACTOR = 3,
    parameter int unsigned PROC_LATENCY       = 2,
    parameter int unsigned OUT_DEPTH          = 4,
    parameter logic [7:0]  PAD_BYTE           = 8'h00
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [7:0]                      s_data_i,
    input  logic                            s_valid_i,
    output logic                            s_ready_o,
    input  logic                            s_last_i,
    output logic                            p_enable_o,
    output logic [8*REPLICATION_FACTOR-1:0] p_in_data_o,
    output logic                            p_in_last_o,
    input  logic [7:0]                      p_out_data_i,
    input  logic                            p_out_valid_i,
    output logic [7:0]                      m_data_o,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic                            m_last_o,
    output logic                            err_sync_o,
    output logic                            busy_o
);

    // Byte index must be able to hold REPLICATION_FACTOR (it is only cleared on issue).
    localparam int unsigned IW = $clog2(REPLICATION_FACTOR + 1);
    localparam int unsigned PW = $clog2(OUT_DEPTH);
    // Shared width for FIFO occupancy, in-flight count and their sum (credit).
    localparam int unsigned NW = $clog2(OUT_DEPTH + PROC_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
`ifdef SEQ_FRAME_GAP_EN
        ST_DRAIN = 2'd2,
`endif
        ST_ISSUE = 2'd1
    } state_e;

    state_e                  state_q, state_d;
    logic                    active_q;      // holds s_ready low for the first cycle after reset
    logic [IW-1:0]           idx_q, idx_d;
    logic                    last_q;
    logic [PROC_LATENCY-1:0] tag_v_q, tag_v_d;
    logic [PROC_LATENCY-1:0] tag_l_q, tag_l_d;
    logic [8:0]              fifo_mem [OUT_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]           count_q;
    logic                    err_q;

    logic                    s_ready;
    logic                    accept;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic [NW-1:0]           inflight;
    logic [NW-1:0]           credit;

    assign accept = s_ready && s_valid_i;
    assign push   = tag_v_q[PROC_LATENCY-1];
    assign pop    = m_valid_o && m_ready_i;
    assign credit = count_q + inflight;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PROC_LATENCY; i++) begin
            inflight = inflight + NW'(tag_v_q[i]);
        end
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        s_ready = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_FILL: begin
                s_ready = active_q;
                if (accept) begin
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IW'(REPLICATION_FACTOR - 1) || s_last_i) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // Occupancy plus in-flight results bounds what the FIFO may
                // have to absorb, so issuing below OUT_DEPTH cannot overflow.
                if (credit < NW'(OUT_DEPTH)) begin
                    issue = 1'b1;
                    idx_d = '0;
`ifdef SEQ_FRAME_GAP_EN
                    state_d = last_q ? ST_DRAIN : ST_FILL;
`else
                    state_d = ST_FILL;
`endif
                end
            end
`ifdef SEQ_FRAME_GAP_EN
            ST_DRAIN: begin
                if (inflight == '0 && count_q == '0) begin
                    state_d = ST_FILL;
                end
            end
`endif
            default: state_d = ST_FILL;
        endcase
    end

    // Tag pipe mirrors the processor latency; the tail marks the result cycle.
    always_comb begin
        tag_v_d    = tag_v_q << 1;
        tag_l_d    = tag_l_q << 1;
        tag_v_d[0] = issue;
        tag_l_d[0] = issue && last_q;
    end

    // ---------------- sequential state ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_FILL;
            active_q <= 1'b0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            tag_v_q  <= '0;
            tag_l_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            idx_q    <= idx_d;
            tag_v_q  <= tag_v_d;
            tag_l_q  <= tag_l_d;
            if (accept) begin
                last_q <= s_last_i;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + NW'(push) - NW'(pop);
            // A tag without a valid, or a valid without a tag, is a sync loss.
            err_q   <= err_q | (push ^ p_out_valid_i);
        end
    end

    // Byte lanes: the accepted byte lands in its lane; an early s_last pads
    // every lane above it so no stale bytes from an earlier word leak out.
    for (genvar gi = 0; gi < REPLICATION_FACTOR; gi++) begin : g_lane
        logic [7:0] lane_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                lane_q <= '0;
            end else if (accept) begin
                if (idx_q == IW'(gi)) begin
                    lane_q <= s_data_i;
                end else if (s_last_i && (idx_q < IW'(gi))) begin
                    lane_q <= PAD_BYTE;
                end
            end
        end
        assign p_in_data_o[8*gi +: 8] = lane_q;
    end

    // The push happens on every tail tag, even if the processor failed to
    // assert valid, so the result stream never loses its frame alignment.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {tag_l_q[PROC_LATENCY-1], p_out_data_i};
        end
    end

    // ---------------- outputs ----------------
    assign s_ready_o   = s_ready;
    assign p_enable_o  = issue;
    assign p_in_last_o = last_q;
    assign m_valid_o   = (count_q != '0);
    assign m_data_o    = m_valid_o ? fifo_mem[rd_ptr_q][7:0] : 8'h00;
    assign m_last_o    = m_valid_o ? fifo_mem[rd_ptr_q][8] : 1'b0;
    assign err_sync_o  = err_q;
    assign busy_o      = (state_q != ST_FILL) || (idx_q != '0) ||
                         (inflight != '0) || (count_q != '0);

endmodule

// File: tb/tb_stateful_processor_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for stateful_processor_sequencer (R=3, latency 2, FIFO depth 4).
// A behavioural model packs the byte stream into expected words, a processor
// model answers every enable after the fixed latency, and a result queue
// scoreboards the downstream stream.
// -----------------------------------------------------------------------------
module tb_stateful_processor_sequencer;

    localparam int          R   = 3;
    localparam int          L   = 2;
    localparam int          D   = 4;
    localparam logic [7:0]  PAD = 8'h00;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [7:0]     s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic           s_last = 1'b0;
    logic           p_enable;
    logic [8*R-1:0] p_in_data;
    logic           p_in_last;
    logic [7:0]     p_out_data = '0;
    logic           p_out_valid = 1'b0;
    logic [7:0]     m_data;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic           m_last;
    logic           err_sync;
    logic           busy;

    stateful_processor_sequencer #(
        .REPLICATION_FACTOR(R),
        .PROC_LATENCY      (L),
        .OUT_DEPTH         (D),
        .PAD_BYTE          (PAD)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_last_i     (s_last),
        .p_enable_o   (p_enable),
        .p_in_data_o  (p_in_data),
        .p_in_last_o  (p_in_last),
        .p_out_data_i (p_out_data),
        .p_out_valid_i(p_out_valid),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_last_o     (m_last),
        .err_sync_o   (err_sync),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    logic [7:0]  tx_d[$];
    logic        tx_l[$];
    logic [7:0]  pk[$];
    logic [24:0] exp_word[$];
    logic [8:0]  exp_res[$];
    logic [7:0]  force_res[$];
    logic        resp_pend[8];
    logic [7:0]  resp_data[8];
    logic        resp_drop[8];
    bit          drop_next = 0;
    int          valid_pct = 100;
    int          mr_mode = 1;
    int          n_en = 0;
    int          n_res = 0;
    logic [24:0] last_word = '0;
    logic [8:0]  last_res = '0;
    int          acc_cyc[$];
    int          en_cyc[$];
    int          hs_cyc[$];
    logic        stall_prev = 1'b0;
    logic [8:0]  stall_val = '0;
    logic        obs_s_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        tx_d.push_back(d);
        tx_l.push_back(l);
    endtask

    // Words close on the R-th byte or on s_last; unused lanes carry PAD.
    task automatic model_accept(input logic [7:0] d, input logic l);
        logic [8*R-1:0] w;
        pk.push_back(d);
        if (l || pk.size() == R) begin
            w = '0;
            for (int k = 0; k < R; k++) w[8*k +: 8] = (k < pk.size()) ? pk[k] : PAD;
            exp_word.push_back({l, w});
            pk.delete();
        end
    endtask

    task automatic clear_trace();
        acc_cyc.delete();
        en_cyc.delete();
        hs_cyc.delete();
    endtask

    // One clock cycle: drive at posedge+1, observe at negedge.
    task automatic step();
        int          slot;
        int          ps;
        logic [24:0] e;
        logic [7:0]  r;
        slot        = cyc % 8;
        s_valid     = (tx_d.size() > 0) && (int'($urandom_range(99, 0)) < valid_pct);
        s_data      = s_valid ? tx_d[0] : 8'($urandom);
        s_last      = s_valid ? tx_l[0] : 1'($urandom);
        m_ready     = (mr_mode == 1) ? 1'b1 : (mr_mode == 0) ? 1'b0 : 1'($urandom);
        p_out_valid = resp_pend[slot] && !resp_drop[slot];
        p_out_data  = resp_pend[slot] ? resp_data[slot] : 8'($urandom);
        resp_pend[slot] = 1'b0;
        @(negedge clk);
        obs_s_ready = s_ready;
        if (stall_prev) begin
            chk("m_hold_valid", 32'(m_valid), 32'd1);
            chk("m_hold_data", 32'({m_last, m_data}), 32'(stall_val));
        end
        stall_prev = m_valid && !m_ready;
        stall_val  = {m_last, m_data};
        if (s_valid && s_ready) begin
            void'(tx_d.pop_front());
            void'(tx_l.pop_front());
            model_accept(s_data, s_last);
            acc_cyc.push_back(cyc);
        end
        if (p_enable) begin
            if (exp_word.size() == 0) begin
                chk("spurious_enable", 32'(p_enable), 32'd0);
            end else begin
                e = exp_word.pop_front();
                chk("p_in_word", 32'({p_in_last, p_in_data}), 32'(e));
                last_word = {p_in_last, p_in_data};
                r  = (force_res.size() > 0) ? force_res.pop_front() : 8'($urandom);
                ps = (cyc + L) % 8;
                resp_pend[ps] = 1'b1;
                resp_data[ps] = r;
                resp_drop[ps] = drop_next;
                drop_next     = 0;
                exp_res.push_back({e[24], r});
                n_en++;
                en_cyc.push_back(cyc);
            end
        end
        if (m_valid && m_ready) begin
            if (exp_res.size() == 0) begin
                chk("spurious_result", 32'(m_valid), 32'd0);
            end else begin
                chk("m_result", 32'({m_last, m_data}), 32'(exp_res.pop_front()));
            end
            last_res = {m_last, m_data};
            n_res++;
            hs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while ((tx_d.size() > 0 || exp_word.size() > 0 || exp_res.size() > 0 ||
                pk.size() > 0) && n < max) begin
            step();
            n++;
        end
        chk("idle_reached", 32'(n < max), 32'd1);
        repeat (2) step();
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    // Asynchronous reset assertion, checked before any clock edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        tx_d.delete(); tx_l.delete(); pk.delete();
        exp_word.delete(); exp_res.delete(); force_res.delete();
        for (int i = 0; i < 8; i++) resp_pend[i] = 1'b0;
        stall_prev = 1'b0;
        drop_next  = 0;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_p_enable", 32'(p_enable), 32'd0);
        chk("rst_p_in", 32'({p_in_last, p_in_data}), 32'd0);
        chk("rst_m_out", 32'({m_valid, m_last, m_data}), 32'd0);
        chk("rst_err", 32'(err_sync), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("s_ready_release_cycle", 32'(obs_s_ready), 32'd0);
        step();
        chk("s_ready_after_first_clk", 32'(obs_s_ready), 32'd1);
    endtask

    initial begin
        int n0;
        int r0;
        int len;
        for (int i = 0; i < 8; i++) begin
            resp_pend[i] = 1'b0;
            resp_data[i] = '0;
            resp_drop[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        apply_reset();

        // 1: one full word, fixed result, latency check
        clear_trace();
        valid_pct = 100; mr_mode = 1;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        force_res.push_back(8'hA5);
        r0 = n_res; n0 = n_en;
        run_idle(100);
        chk("s1_word", 32'(last_word), 32'h0332211);
        chk("s1_result", 32'(last_res), 32'h0A5);
        chk("s1_enables", 32'(n_en - n0), 32'd1);
        chk("s1_results", 32'(n_res - r0), 32'd1);
        chk("s1_enable_latency", 32'(en_cyc[0]), 32'(acc_cyc[2] + 1));
        chk("s1_mvalid_latency", 32'(hs_cyc[0]), 32'(acc_cyc[2] + 2 + L));

        // 2: short frame with padding
        send(8'h01, 0); send(8'h02, 1);
        run_idle(100);
        chk("s2_word", 32'(last_word), 32'h1000201);
        chk("s2_m_last", 32'(last_res[8]), 32'd1);

        // 3: downstream stalled, credit limit
        mr_mode = 0;
        for (int i = 0; i < 18; i++) send(8'($urandom), 0);
        n0 = n_en;
        repeat (40) step();
        chk("s3_enables", 32'(n_en - n0), 32'd4);
        chk("s3_s_ready", 32'(obs_s_ready), 32'd0);
        chk("s3_tx_left", 32'(tx_d.size()), 32'd3);
        r0 = n_res;
        mr_mode = 1;
        run_idle(300);
        chk("s3_results", 32'(n_res - r0), 32'd6);

        // Randomized frames with random gaps and backpressure
        valid_pct = 60; mr_mode = 2;
        for (int f = 0; f < 8; f++) begin
            len = int'($urandom_range(8, 1));
            for (int b = 0; b < len; b++) send(8'($urandom), b == len - 1);
        end
        run_idle(3000);
        chk("rand_err_clean", 32'(err_sync), 32'd0);

        // 4: dropped processor valid
        valid_pct = 100; mr_mode = 1;
        drop_next = 1;
        r0 = n_res;
        send(8'hA0, 0); send(8'hB0, 0); send(8'hC0, 0);
        run_idle(100);
        chk("s4_err_set", 32'(err_sync), 32'd1);
        chk("s4_entry_kept", 32'(n_res - r0), 32'd1);
        send(8'h5A, 1);
        run_idle(100);
        chk("s4_err_sticky", 32'(err_sync), 32'd1);

        // 5: reset mid-operation
        mr_mode = 0;
        for (int i = 0; i < 7; i++) send(8'($urandom), 0);
        repeat (10) step();
        chk("s5_busy_mid", 32'(busy), 32'd1);
        apply_reset();
        mr_mode = 1;
        r0 = n_res;
        send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
        run_idle(100);
        chk("s5_clean_word", 32'(last_word), 32'h0665544);
        chk("s5_results", 32'(n_res - r0), 32'd1);
        chk("s5_err_clear", 32'(err_sync), 32'd0);

        // 6: back-to-back frames
        clear_trace();
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 1);
        send(8'h40, 0); send(8'h50, 0); send(8'h60, 1);
        run_idle(200);
`ifdef SEQ_FRAME_GAP_EN
        chk("s6_gap_wait", 32'(acc_cyc[3] > hs_cyc[0]), 32'd1);
`else
        chk("s6_b_accept", 32'(acc_cyc[3]), 32'(en_cyc[0] + 1));
`endif
        chk("s6_words", 32'(en_cyc.size()), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
